// File: rtl/clk_divider_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one system clock.
// Each channel emits a registered square wave and a last-cycle-of-period tick strobe.
module clk_divider_bank #(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [CHANNELS-1:0]                           en,
  input  logic                                          sync,
  input  logic                                          cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_sel,
  input  logic [WIDTH-1:0]                              cfg_div,
  output logic [CHANNELS-1:0]                           wave,
  output logic [CHANNELS-1:0]                           tick
);

  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] shd_reg;
      logic [WIDTH-1:0] act_reg;
      logic [WIDTH-1:0] cnt_reg;
      logic             wave_reg;
      logic             tick_reg;

      logic             wr_hit;
      logic             act_zero;
      logic             at_wrap;
      logic             high_phase;
      logic             restart;
      logic [WIDTH-1:0] load_div;
      logic [WIDTH-1:0] cnt_next;
      logic [WIDTH:0]   half_act;

      // Out-of-range selects never match any channel index, so they are dropped.
      assign wr_hit     = cfg_we && (cfg_sel == SELW'(gi));
      assign act_zero   = (act_reg == '0);
      assign at_wrap    = !act_zero && (cnt_reg == act_reg - WIDTH'(1));
      assign half_act   = ({1'b0, act_reg} + (WIDTH+1)'(1)) >> 1;
      assign high_phase = ({1'b0, cnt_reg} < half_act);
      assign cnt_next   = at_wrap ? '0 : cnt_reg + WIDTH'(1);

      // A write landing on a divisor load goes straight into act.
      assign load_div   = wr_hit ? cfg_div : shd_reg;

      // Disable, sync and halted channels all park at phase 0 with outputs low.
      assign restart    = !en[gi] || sync || act_zero;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shd_reg  <= DEF_DIV;
          act_reg  <= DEF_DIV;
          cnt_reg  <= '0;
          wave_reg <= 1'b0;
          tick_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            shd_reg <= cfg_div;
          end
          if (restart) begin
            cnt_reg  <= '0;
            wave_reg <= 1'b0;
            tick_reg <= 1'b0;
            act_reg  <= load_div;
          end else begin
            cnt_reg  <= cnt_next;
            wave_reg <= high_phase;
            tick_reg <= at_wrap;
            if (at_wrap) begin
              act_reg <= load_div;
            end
          end
        end
      end

      assign wave[gi] = wave_reg;
      assign tick[gi] = tick_reg;
    end
  endgenerate

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Multi-channel, runtime-programmable clock divider. It generalises the fixed one-per-LED divider instances into one block with N channels clocked from a single system clock. Each channel has a per-channel divisor, an enable, a square-wave output and a one-cycle tick strobe. Divisors are updated glitch-free at period boundaries, and a global sync re-aligns all channel phases. It sits between the system clock domain and LED/status heartbeat logic or slow-rate enable consumers.

## Interface
- CHANNELS, 3, number of independent divider channels (1..16)
- WIDTH, 26, divisor and counter width in bits
- DEFAULT_DIV, 50000000, reset divisor for every channel, truncated to WIDTH bits
- clk  input  1  system clock; all logic is on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- en  input  CHANNELS  per-channel run enable, level
- sync  input  1  single-cycle phase-align strobe for all channels
- cfg_we  input  1  divisor write strobe
- cfg_sel  input  max(1,$clog2(CHANNELS))  channel index for the write
- cfg_div  input  WIDTH  new divisor, full period in clk cycles
- wave  output  CHANNELS  divided square wave, registered
- tick  output  CHANNELS  one-cycle strobe, last cycle of each period, registered

## Operation
- Per-channel state: shadow divisor `shd`, active divisor `act`, counter `cnt`, and output registers.
- Reset, sampled at a clk edge with rst_n=0: shd=act=DEFAULT_DIV, cnt=0, wave=0, tick=0 for all channels.
- Counter update: cnt runs 0..act-1. On each enabled edge, cnt <= (cnt==act-1) ? 0 : cnt+1. The step with cnt==act-1 is a "wrap".
- Output registers load from the pre-edge cnt:
  - wave <= (cnt < (act+1)>>1)
  - tick <= (cnt == act-1)
  - For odd act, the high phase is one cycle longer.
- act=1: cnt stays 0; wave is held 1; tick is high every cycle.
- act=0: channel is halted. cnt=0, wave<=0, tick<=0. A new nonzero write loads immediately.
- Config write (cfg_we=1, cfg_sel<CHANNELS) updates shd[sel]. A write with cfg_sel>=CHANNELS is ignored.
- act loads from shd in these cases:
  - at a wrap;
  - whenever the channel is disabled;
  - whenever act=0;
  - on sync.
- If a write and a wrap hit the same channel in the same cycle, cfg_div bypasses shd and loads into act directly. It takes effect for the next period.
- Disable (en[i]=0): on the next edge cnt<=0, wave<=0, tick<=0, act<=shd. While disabled, these values are held.
- Re-enable restarts at phase 0: the first enabled edge produces wave=1.
- sync=1: every enabled channel takes cnt<=0, act<=shd (or bypassed cfg_div), wave<=0, tick<=0. Normal counting resumes on the following edge. Disabled channels are unaffected beyond the disable behaviour.
- Priority per channel: rst_n=0 > en=0 > sync > normal count.
- Channels are fully independent except for the shared sync and cfg bus.

## Timing
- Latency: outputs lag cnt by one clk. After release of reset, or after enable, the first active edge drives wave=1.
- Output pattern with act=4 from the first active edge: wave 1,1,0,0,1,1,0,0…; tick 0,0,0,1,0,0,0,1….
- Tick period is exactly act cycles. The tick pulse width is exactly 1 cycle (except act=1, where tick is held high).
- Divisor change takes effect at the first wrap after the write, or at the same wrap via bypass. wave never shows a partial period mixing old and new divisors.
- Reset mid-period: all outputs are 0 on the cycle after the reset edge. No stale tick survives.
- No combinational path from any input to wave or tick.

## Test plan
- Reset, then en=3'b111, defaults overridden to act=4 via cfg writes while disabled: wave=1,1,0,0 repeating and tick high every 4th cycle, coincident with the last low cycle, on all channels.
- Channel 0 running at act=6. Write cfg_div=3 at cnt=2: the current period completes at 6 cycles, then wave=1,1,0 and tick period is 3. Repeat with the write landing exactly on the wrap cycle: the 3-cycle period starts immediately (bypass).
- act values 0, 1, 2, 5:
  - 0: wave=0, tick=0, held.
  - 1: wave=1, tick=1 constantly.
  - 2: wave alternates 1,0.
  - 5: wave=1,1,1,0,0, tick period 5.
- Channels at act=4, 5, 7 with random phase. Pulse sync: the next cycle all wave=0 and tick=0, then all three show wave=1 simultaneously and count from phase 0.
- Deassert en[1] mid-period for 3 cycles while writing cfg_sel=1, cfg_div=8: wave[1]=tick[1]=0 while disabled. On re-enable, wave[1] runs 4 high, 4 low. Other channels are undisturbed.
- Assert rst_n=0 for one cycle mid-period with act=10: the next cycle all outputs are 0 and act=DEFAULT_DIV. Write cfg_sel=CHANNELS (out of range): no channel changes.
